player_vmotion: RTL and testbench



---
 rtl/player_vmotion.sv | 228 ++++++++++++++++++++++
 tb/tb_player_vmotion.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_vmotion.sv
// player_vmotion -- vertical-motion controller for the player sprite.
//
// Runs the jump / rise / fall / landing state machine once per video frame
// (on frame_tick). Platform landing levels are fixed at 644, 479, 302, 175
// (levels 1..4); ground_mask tells which of them lie under the player's x.
//
// Optional feature: define PLAYER_DOUBLE_JUMP_EN to allow one extra jump
// while airborne (re-armed on landing or respawn).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   frame_tick   one-cycle pulse per frame; all motion happens on it
//   jump         jump button (level); a rising edge posts a request
//   respawn      one-cycle pulse; back to the start position
//   ground_mask  bit i = platform at level i+1 under the player
//   ypos         vertical position (sprite foot line)
//   level        current/last platform index (0 = level 1)
//   airborne     high while RISING or FALLING
//   landed       one-cycle pulse on landing
//   fell_out     one-cycle pulse on entering OUT
module player_vmotion #(
    parameter int JUMP_V0 = 8,
    parameter int GRAVITY = 1,
    parameter int VMAX    = 8,
    parameter int Y_LIMIT = 767
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        jump,
    input  logic        respawn,
    input  logic [3:0]  ground_mask,
    output logic [10:0] ypos,
    output logic [1:0]  level,
    output logic        airborne,
    output logic        landed,
    output logic        fell_out
);
    typedef enum logic [1:0] {GROUNDED, RISING, FALLING, OUT} state_t;

    localparam logic [10:0] Y_START = 11'd644;
    localparam logic [3:0]  V0      = 4'(JUMP_V0);
    localparam logic [3:0]  GRAV    = 4'(GRAVITY);
    localparam logic [3:0]  VCAP    = 4'(VMAX);
    localparam logic [11:0] YLIM    = 12'(Y_LIMIT);

    function automatic logic [11:0] level_y(input logic [1:0] idx);
        case (idx)
            2'd0:    level_y = 12'd644;
            2'd1:    level_y = 12'd479;
            2'd2:    level_y = 12'd302;
            default: level_y = 12'd175;
        endcase
    endfunction

    // Falling speed after one frame of gravity, clamped to the terminal speed.
    function automatic logic [3:0] fall_vel(input logic [3:0] v);
        logic [4:0] sum;
        sum = {1'b0, v} + {1'b0, GRAV};
        if (sum > {1'b0, VCAP}) fall_vel = VCAP;
        else                    fall_vel = sum[3:0];
    endfunction

    state_t      state, state_nx;
    logic [3:0]  vel, vel_nx;
    logic [10:0] ypos_nx;
    logic [1:0]  level_nx;
    logic        airborne_nx, landed_nx, fell_nx;
    logic        req, req_nx, req_now, jump_q;
    logic        do_rise;
    logic [3:0]  rise_v;
    logic [3:0]  fv;
    logic [11:0] ynext;
    logic        hit;
    logic [1:0]  hit_idx;
`ifdef PLAYER_DOUBLE_JUMP_EN
    logic        armed, armed_nx;
`endif

    // Candidate falling step, evaluated every cycle from the current state.
    // Ascending scan lets the highest crossed index (smallest level y) win.
    always_comb begin
        fv      = fall_vel(vel);
        ynext   = {1'b0, ypos} + {8'd0, fv};
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (ground_mask[i] && ({1'b0, ypos} < level_y(2'(i)))
                && (level_y(2'(i)) <= ynext)) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        vel_nx    = vel;
        ypos_nx   = ypos;
        level_nx  = level;
        landed_nx = 1'b0;
        fell_nx   = 1'b0;
        do_rise   = 1'b0;
        rise_v    = vel;
        // An edge arriving in the tick cycle still counts for that tick.
        req_now   = req | (jump & ~jump_q);
        req_nx    = frame_tick ? 1'b0 : req_now;
`ifdef PLAYER_DOUBLE_JUMP_EN
        armed_nx  = armed;
`endif
        if (frame_tick) begin
            case (state)
                GROUNDED: begin
                    // Walking off an edge outranks a jump request.
                    if (!ground_mask[level]) begin
                        state_nx = FALLING;
                        vel_nx   = 4'd0;
                    end else if (req_now) begin
                        do_rise = 1'b1;
                        rise_v  = V0;
                    end
                end
                RISING: begin
                    do_rise = 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
                    if (req_now && armed) begin
                        rise_v   = V0;
                        armed_nx = 1'b0;
                    end
`endif
                end
                FALLING: begin
`ifdef PLAYER_DOUBLE_JUMP_EN
                    if (req_now && armed) begin
                        do_rise  = 1'b1;
                        rise_v   = V0;
                        armed_nx = 1'b0;
                    end else
`endif
                    if (hit) begin
                        ypos_nx   = level_y(hit_idx)[10:0];
                        level_nx  = hit_idx;
                        vel_nx    = 4'd0;
                        state_nx  = GROUNDED;
                        landed_nx = 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
                        armed_nx  = 1'b1;
`endif
                    end else if (ynext > YLIM) begin
                        ypos_nx  = YLIM[10:0];
                        vel_nx   = fv;
                        state_nx = OUT;
                        fell_nx  = 1'b1;
                    end else begin
                        ypos_nx = ynext[10:0];
                        vel_nx  = fv;
                    end
                end
                default: ;
            endcase

            // Launching and rising share one step: move up by the current
            // speed, then decelerate; clamp at the top of the screen.
            if (do_rise) begin
                if ({7'd0, rise_v} > ypos) begin
                    ypos_nx  = 11'd0;
                    vel_nx   = 4'd0;
                    state_nx = FALLING;
                end else begin
                    ypos_nx = ypos - {7'd0, rise_v};
                    if (rise_v <= GRAV) begin
                        vel_nx   = 4'd0;
                        state_nx = FALLING;
                    end else begin
                        vel_nx   = rise_v - GRAV;
                        state_nx = RISING;
                    end
                end
            end
        end

        if (respawn) begin
            state_nx  = GROUNDED;
            vel_nx    = 4'd0;
            ypos_nx   = Y_START;
            level_nx  = 2'd0;
            landed_nx = 1'b0;
            fell_nx   = 1'b0;
            req_nx    = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            armed_nx  = 1'b1;
`endif
        end

        airborne_nx = (state_nx == RISING) || (state_nx == FALLING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= GROUNDED;
            vel      <= 4'd0;
            ypos     <= Y_START;
            level    <= 2'd0;
            airborne <= 1'b0;
            landed   <= 1'b0;
            fell_out <= 1'b0;
            req      <= 1'b0;
            jump_q   <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            armed    <= 1'b1;
`endif
        end else begin
            state    <= state_nx;
            vel      <= vel_nx;
            ypos     <= ypos_nx;
            level    <= level_nx;
            airborne <= airborne_nx;
            landed   <= landed_nx;
            fell_out <= fell_nx;
            req      <= req_nx;
            jump_q   <= jump;
`ifdef PLAYER_DOUBLE_JUMP_EN
            armed    <= armed_nx;
`endif
        end
    end
endmodule

// File: tb/tb_player_vmotion.sv
module tb_player_vmotion;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        jump = 1'b0;
    logic        respawn = 1'b0;
    logic [3:0]  ground_mask = 4'b0001;
    logic [10:0] ypos;
    logic [1:0]  level;
    logic        airborne;
    logic        landed;
    logic        fell_out;

    always #5 clk = ~clk;

    player_vmotion dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .jump       (jump),
        .respawn    (respawn),
        .ground_mask(ground_mask),
        .ypos       (ypos),
        .level      (level),
        .airborne   (airborne),
        .landed     (landed),
        .fell_out   (fell_out)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain integer physics. Modes: 0 ground, 1 up, 2 down, 3 out.
    int m_y, m_v, m_lvl, m_mode;
    bit m_landed, m_fell, m_req, m_jprev, m_armed;
    int lv_y [4] = '{644, 479, 302, 175};

    task automatic model_reset();
        m_y = 644; m_v = 0; m_lvl = 0; m_mode = 0;
        m_landed = 0; m_fell = 0; m_req = 0; m_armed = 1;
    endtask

    task automatic model_rise(input int speed);
        if (speed > m_y) begin
            m_y = 0; m_v = 0; m_mode = 2;
        end else begin
            m_y = m_y - speed;
            m_v = speed - 1;
            m_mode = (m_v == 0) ? 2 : 1;
        end
    endtask

    task automatic model_fall(input logic [3:0] mask);
        int yn, best;
        m_v = (m_v + 1 > 8) ? 8 : m_v + 1;
        yn = m_y + m_v;
        best = -1;
        for (int i = 0; i < 4; i++)
            if (mask[i] && m_y < lv_y[i] && lv_y[i] <= yn)
                if (best < 0 || lv_y[i] < lv_y[best]) best = i;
        if (best >= 0) begin
            m_y = lv_y[best]; m_lvl = best; m_v = 0; m_mode = 0;
            m_landed = 1; m_armed = 1;
        end else if (yn > 767) begin
            m_y = 767; m_mode = 3; m_fell = 1;
        end else begin
            m_y = yn;
        end
    endtask

    task automatic model_cycle(input bit t, input bit j, input bit r, input logic [3:0] mask);
        bit req_now, dj;
        req_now = m_req || (j && !m_jprev);
        m_jprev = j;
        m_landed = 0;
        m_fell = 0;
        dj = 0;
`ifdef PLAYER_DOUBLE_JUMP_EN
        dj = 1;
`endif
        if (r) begin
            model_reset();
        end else begin
            if (t) begin
                if (m_mode == 0) begin
                    if (!mask[m_lvl]) begin m_mode = 2; m_v = 0; end
                    else if (req_now) model_rise(8);
                end else if (m_mode == 1 || m_mode == 2) begin
                    if (dj && req_now && m_armed) begin
                        m_armed = 0;
                        model_rise(8);
                    end else if (m_mode == 1) model_rise(m_v);
                    else model_fall(mask);
                end
            end
            m_req = t ? 0 : req_now;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ypos", {21'd0, ypos}, 32'(m_y));
        chk("level", {30'd0, level}, 32'(m_lvl));
        chk("airborne", {31'd0, airborne}, 32'(m_mode == 1 || m_mode == 2));
        chk("landed", {31'd0, landed}, 32'(m_landed));
        chk("fell_out", {31'd0, fell_out}, 32'(m_fell));
    endtask

    task automatic step(input bit t, input bit j, input bit r, input logic [3:0] m);
        frame_tick = t; jump = j; respawn = r; ground_mask = m;
        @(posedge clk);
        model_cycle(t, j, r, m);
        #1;
        check_all();
        frame_tick = 1'b0;
        respawn = 1'b0;
    endtask

    initial begin
        int jseq [16] = '{636, 629, 623, 618, 614, 611, 609, 608,
                          609, 611, 614, 618, 623, 629, 636, 644};
        int fell_cnt;
        bit rt, rj, rr;
        logic [3:0] rm;

        // Reset and idle
        model_reset();
        m_jprev = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1, 0, 0, 4'b0001);
            step(0, 0, 0, 4'b0001);
        end
        chk("idle_ypos", {21'd0, ypos}, 644);

        // Full jump, request posted before the tick
        step(0, 1, 0, 4'b0001);
        step(0, 0, 0, 4'b0001);
        for (int k = 0; k < 16; k++) begin
            step(1, 0, 0, 4'b0001);
            chk("jump_seq", {21'd0, ypos}, 32'(jseq[k]));
        end
        chk("jump_landed", {31'd0, landed}, 1);
        chk("jump_level", {30'd0, level}, 0);

        // Edge in tick cycle honoured; held button does not retrigger
        step(1, 1, 0, 4'b0001);
        chk("edge_on_tick", {21'd0, ypos}, 636);
        for (int k = 0; k < 20; k++) step(1, 1, 0, 4'b0001);
        chk("held_no_retrigger", {21'd0, ypos}, 644);
        chk("held_grounded", {31'd0, airborne}, 0);

        // Jump while rising
        step(1, 0, 0, 4'b0001);
        step(1, 1, 0, 4'b0001);
        step(1, 0, 0, 4'b0001);
        step(1, 1, 0, 4'b0001);
`ifndef PLAYER_DOUBLE_JUMP_EN
        chk("air_jump_ignored", {21'd0, ypos}, 623);
`else
        chk("air_jump_reload", {21'd0, ypos}, 621);
`endif
        for (int k = 0; k < 40; k++) step(1, 0, 0, 4'b0001);
        chk("settle_after_air", {21'd0, ypos}, 644);

`ifdef PLAYER_DOUBLE_JUMP_EN
        // Double jump at the apex
        step(1, 1, 0, 4'b0001);
        for (int k = 0; k < 7; k++) step(1, 0, 0, 4'b0001);
        chk("apex", {21'd0, ypos}, 608);
        step(0, 1, 0, 4'b0001);
        step(1, 0, 0, 4'b0001);
        chk("double_jump", {21'd0, ypos}, 600);
        for (int k = 0; k < 40; k++) step(1, 0, 0, 4'b0001);
        chk("dj_settle", {21'd0, ypos}, 644);
`endif

        // Walk off with nothing below: fall out, then respawn with a tick
        fell_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step(1, 0, 0, 4'b0000);
            if (fell_out) fell_cnt++;
        end
        chk("fall_out_ypos", {21'd0, ypos}, 767);
        chk("fell_out_once", 32'(fell_cnt), 1);
        chk("out_airborne", {31'd0, airborne}, 0);
        step(1, 1, 0, 4'b0001);
        chk("out_frozen", {21'd0, ypos}, 767);
        step(1, 0, 1, 4'b0001);
        chk("respawn_ypos", {21'd0, ypos}, 644);
        step(1, 0, 0, 4'b0001);
        chk("respawn_grounded", {31'd0, airborne}, 0);

        // Reset mid-jump
        step(1, 1, 0, 4'b0001);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 4'b0001);
        chk("pre_reset_ypos", {21'd0, ypos}, 614);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        m_jprev = 0;
        check_all();
        chk("async_reset_ypos", {21'd0, ypos}, 644);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 4'b0001);
        chk("post_reset_ypos", {21'd0, ypos}, 644);

        // Randomized traffic
        rj = 0;
        for (int k = 0; k < 400; k++) begin
            rt = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) rj = ~rj;
            rr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) rm = 4'($urandom);
            else rm = 4'b0001 | 4'($urandom_range(0, 15));
            step(rt, rj, rr, rm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
